if_neuron: RTL and testbench

Integrate-and-fire neuron that consumes the per-neuron `neuron_rst` produced by the IF layer controller and produces the `spike_in` bit that controller samples. Accumulates weighted input spikes into a saturating membrane potential, emits a one-cycle spike on threshold crossing, then holds until the controller's reset arrives and sits out a refractory window. One instance per neuron in an IF layer.

---
 rtl/snn_pkg.sv | 25 ++
 rtl/weighted_spike_sum.sv | 29 ++
 rtl/if_neuron.sv | 118 +++++++++++
 tb/tb_if_neuron.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// ============================================================================
//  Module   : snn_pkg
//  Brief    : Shared neuron state encoding and width helper for the IF layer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package snn_pkg;

  typedef enum logic [1:0] {
    ST_INTEG  = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REFRAC = 2'd2
  } neuron_state_e;

  // Width able to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/weighted_spike_sum.sv
// ============================================================================
//  Module   : weighted_spike_sum
//  Brief    : Combinational sum of the weights whose presynaptic spike is set.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module weighted_spike_sum #(
  parameter  int NUM_INPUTS = 4,
  parameter  int WEIGHT_W   = 8,
  localparam int SUM_W      = WEIGHT_W + $clog2(NUM_INPUTS + 1)
) (
  input  logic [NUM_INPUTS-1:0]          spike_in,
  input  logic [NUM_INPUTS*WEIGHT_W-1:0] weights,
  output logic [SUM_W-1:0]               sum
);

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (spike_in[i]) begin
        sum = sum + SUM_W'(weights[i*WEIGHT_W +: WEIGHT_W]);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_neuron.sv
// ============================================================================
//  Module   : if_neuron
//  Brief    : Integrate-and-fire neuron with saturating potential, post-spike
//             hold until controller reset, and a refractory window.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_neuron
  import snn_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int WEIGHT_W   = 8,
  parameter int POT_W      = 16,
  parameter int THRESH     = 100,
  parameter int REFRAC     = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_INPUTS-1:0]          spike_in,
  input  logic [NUM_INPUTS*WEIGHT_W-1:0] weights,
  input  logic                           neuron_rst,
  output logic                           spike_out,
  output logic [POT_W-1:0]               mem_pot,
  output logic                           refrac
);

  localparam int SUM_W = WEIGHT_W + $clog2(NUM_INPUTS + 1);
  localparam int EXT_W = ((POT_W > SUM_W) ? POT_W : SUM_W) + 1;
  localparam int CNT_W = cnt_width(REFRAC);

  localparam logic [POT_W-1:0] POT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(REFRAC);
  localparam logic [EXT_W-1:0] THRESH_EXT = EXT_W'(THRESH);

  neuron_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POT_W-1:0] mem_pot_q, mem_pot_d;
  logic             spike_out_q, spike_out_d;

  logic [SUM_W-1:0] w_sum;
  logic [EXT_W-1:0] w_pot_ext;
  logic [POT_W-1:0] w_v_next;
  logic             w_fire;

  weighted_spike_sum #(
    .NUM_INPUTS (NUM_INPUTS),
    .WEIGHT_W   (WEIGHT_W)
  ) u_sum (
    .spike_in (spike_in),
    .weights  (weights),
    .sum      (w_sum)
  );

  // Extended add so neither operand can wrap before the saturation check.
  assign w_pot_ext = EXT_W'(mem_pot_q) + EXT_W'(w_sum);
  assign w_v_next  = (w_pot_ext > EXT_W'(POT_MAX)) ? POT_MAX : w_pot_ext[POT_W-1:0];
  assign w_fire    = EXT_W'(w_v_next) >= THRESH_EXT;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_pot_d   = mem_pot_q;
    spike_out_d = 1'b0;
    if (neuron_rst) begin
      mem_pot_d = '0;
      if (REFRAC > 0) begin
        state_d = ST_REFRAC;
        cnt_d   = CNT_LOAD;
      end else begin
        state_d = ST_INTEG;
      end
    end else begin
      case (state_q)
        ST_INTEG: begin
          mem_pot_d = w_v_next;
          if (w_fire) begin
            spike_out_d = 1'b1;
            state_d     = ST_HOLD;
          end
        end
        ST_HOLD: begin
          state_d = ST_HOLD;
        end
        ST_REFRAC: begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_INTEG;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_INTEG;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INTEG;
      cnt_q       <= '0;
      mem_pot_q   <= '0;
      spike_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_pot_q   <= mem_pot_d;
      spike_out_q <= spike_out_d;
    end
  end

  assign spike_out = spike_out_q;
  assign mem_pot   = mem_pot_q;
  assign refrac    = (state_q != ST_INTEG);

endmodule

`default_nettype wire

// File: tb/tb_if_neuron.sv
// ============================================================================
//  Module   : tb_if_neuron
//  Brief    : Self-checking bench for if_neuron: default, saturating and
//             zero-refractory instances against a behavioural neuron model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_neuron;

  typedef struct packed {
    int pot;
    int left;
    bit hold;
    bit spk;
  } mst_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  sp0 = '0, sp1 = '0, sp2 = '0;
  logic [31:0] wt0 = '0, wt1 = '0, wt2 = '0;
  logic        nr0 = 1'b1, nr1 = 1'b1, nr2 = 1'b1;
  logic        so0, so1, so2, rf0, rf1, rf2;
  logic [15:0] pot0, pot2;
  logic [7:0]  pot1;
  bit          cmp_en = 1'b0;
  int          errors = 0;
  int          checks = 0;
  mst_t        m0, m1, m2;

  always #5 clk = ~clk;

  if_neuron #(.NUM_INPUTS(4), .WEIGHT_W(8), .POT_W(16), .THRESH(100), .REFRAC(5)) u_dut0 (
    .clk(clk), .rst(rst), .spike_in(sp0), .weights(wt0), .neuron_rst(nr0),
    .spike_out(so0), .mem_pot(pot0), .refrac(rf0));

  if_neuron #(.NUM_INPUTS(4), .WEIGHT_W(8), .POT_W(8), .THRESH(255), .REFRAC(5)) u_dut1 (
    .clk(clk), .rst(rst), .spike_in(sp1), .weights(wt1), .neuron_rst(nr1),
    .spike_out(so1), .mem_pot(pot1), .refrac(rf1));

  if_neuron #(.NUM_INPUTS(4), .WEIGHT_W(8), .POT_W(16), .THRESH(100), .REFRAC(0)) u_dut2 (
    .clk(clk), .rst(rst), .spike_in(sp2), .weights(wt2), .neuron_rst(nr2),
    .spike_out(so2), .mem_pot(pot2), .refrac(rf2));

  function automatic int wsum(input logic [3:0] sp, input logic [31:0] wt);
    int s = 0;
    for (int i = 0; i < 4; i++) if (sp[i]) s += int'(wt[i*8 +: 8]);
    return s;
  endfunction

  // Neuron rules: reset request wins, a fired neuron waits for it, then sits
  // out `rf` edges before integrating again.
  function automatic mst_t step(input mst_t s, input logic [3:0] sp, input logic [31:0] wt,
                                input logic nr, input int mx, input int th, input int rf);
    mst_t n = s;
    int   v;
    n.spk = 1'b0;
    if (nr) begin
      n.pot = 0; n.left = rf; n.hold = 1'b0;
    end else if (s.hold) begin
      n.hold = 1'b1;
    end else if (s.left > 0) begin
      n.left = s.left - 1;
    end else begin
      v = s.pot + wsum(sp, wt);
      if (v > mx) v = mx;
      n.pot = v;
      if (v >= th) begin
        n.spk = 1'b1; n.hold = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m0 <= '0; m1 <= '0; m2 <= '0;
    end else begin
      m0 <= step(m0, sp0, wt0, nr0, 65535, 100, 5);
      m1 <= step(m1, sp1, wt1, nr1, 255, 255, 5);
      m2 <= step(m2, sp2, wt2, nr2, 65535, 100, 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_inst(input int idx, input logic s, input logic [31:0] p,
                            input logic r, input mst_t m);
    chk($sformatf("model_i%0d_spike", idx), {31'd0, s}, {31'd0, m.spk});
    chk($sformatf("model_i%0d_pot", idx), p, m.pot);
    chk($sformatf("model_i%0d_refrac", idx), {31'd0, r}, {31'd0, (m.hold || m.left > 0)});
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check_inst(0, so0, {16'd0, pot0}, rf0, m0);
      check_inst(1, so1, {24'd0, pot1}, rf1, m1);
      check_inst(2, so2, {16'd0, pot2}, rf2, m2);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("reset_pot", {16'd0, pot0}, 0);
    chk("reset_spike", {31'd0, so0}, 0);
    chk("reset_refrac", {31'd0, rf0}, 0);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    nr0 = 1'b0; nr1 = 1'b0; nr2 = 1'b0;
    repeat (7) @(negedge clk);
    chk("startup_refrac_done", {31'd0, rf0}, 0);

    // Basic integration: 30 per edge up to the 120 crossing.
    wt0 = {4{8'd30}}; sp0 = 4'b0001;
    @(negedge clk); chk("integ_30", {16'd0, pot0}, 30);
    @(negedge clk); chk("integ_60", {16'd0, pot0}, 60);
    @(negedge clk); chk("integ_90", {16'd0, pot0}, 90);
    @(negedge clk); chk("integ_120", {16'd0, pot0}, 120);
    chk("fire_pulse", {31'd0, so0}, 1);
    @(negedge clk);
    chk("fire_one_cycle", {31'd0, so0}, 0);
    chk("hold_pot", {16'd0, pot0}, 120);
    chk("hold_refrac", {31'd0, rf0}, 1);
    nr0 = 1'b1;
    @(negedge clk);
    chk("loop_clear_pot", {16'd0, pot0}, 0);
    chk("loop_refrac", {31'd0, rf0}, 1);
    nr0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("refrac_pot_blocked", {16'd0, pot0}, 0);
      chk("refrac_window", {31'd0, rf0}, (i < 4) ? 1 : 0);
    end
    @(negedge clk); chk("resume_integ", {16'd0, pot0}, 30);
    sp0 = 4'b0000;

    // Saturation on an 8-bit potential.
    wt1 = {4{8'd200}}; sp1 = 4'b1111;
    @(negedge clk);
    chk("sat_pot", {24'd0, pot1}, 255);
    chk("sat_fire", {31'd0, so1}, 1);
    sp1 = 4'b0000; nr1 = 1'b1;
    @(negedge clk);
    nr1 = 1'b0;
    chk("sat_clear", {24'd0, pot1}, 0);

    // neuron_rst on the would-be crossing edge.
    sp0 = 4'b0001;
    @(negedge clk);
    @(negedge clk); chk("prec_pre_90", {16'd0, pot0}, 90);
    nr0 = 1'b1;
    @(negedge clk);
    chk("prec_no_spike", {31'd0, so0}, 0);
    chk("prec_pot", {16'd0, pot0}, 0);
    chk("prec_refrac", {31'd0, rf0}, 1);
    nr0 = 1'b0; sp0 = 4'b0000;
    repeat (6) @(negedge clk);

    // REFRAC = 0 instance.
    wt2 = {24'd0, 8'd120}; sp2 = 4'b0001;
    @(negedge clk);
    chk("r0_fire", {31'd0, so2}, 1);
    chk("r0_pot", {16'd0, pot2}, 120);
    chk("r0_hold_refrac", {31'd0, rf2}, 1);
    nr2 = 1'b1;
    @(negedge clk);
    chk("r0_clear", {16'd0, pot2}, 0);
    chk("r0_no_refrac", {31'd0, rf2}, 0);
    nr2 = 1'b0; wt2 = {24'd0, 8'd50};
    @(negedge clk);
    chk("r0_next_edge_integ", {16'd0, pot2}, 50);
    chk("r0_refrac_low", {31'd0, rf2}, 0);
    sp2 = 4'b0000;

    // Asynchronous reset with the refractory counter at 3.
    nr0 = 1'b1;
    @(negedge clk);
    nr0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("async_pre_refrac", {31'd0, rf0}, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_refrac_now", {31'd0, rf0}, 0);
    chk("async_pot_now", {16'd0, pot2}, 0);
    chk("async_spike_now", {31'd0, so0}, 0);
    wt0 = {4{8'd30}}; sp0 = 4'b0001;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("async_first_integ", {16'd0, pot0}, 30);
    chk("async_integ_refrac", {31'd0, rf0}, 0);
    sp0 = 4'b0000;

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
